// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit processor: opcodes, alu operation codes
// and the instruction sequencer state encoding.
package cpu_pkg;

  // Opcodes carried in IR[7:5]
  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  // alu operation select codes
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ZERO = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_SHL  = 3'b100;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_IR    = 3'd2,
    S_DEC   = 3'd3,
    S_OPND  = 3'd4,
    S_SKZ   = 3'd5,
    S_WB    = 3'd6,
    S_HALT  = 3'd7
  } state_t;

endpackage

// File: rtl/cpu_ctrl.sv
// Instruction sequencer: walks each instruction through fetch, decode,
// operand read, execute and write-back. Outputs are a pure decode of the
// state register and the opcode, so reset clears them immediately.
//
// Handshake note: there is no valid/ready handshake here; memory reads are
// fixed-latency (data valid the cycle after mem_rd) and start is a level
// sampled only in IDLE or HALT.
module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic       alu_zero,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       addr_sel,
  output logic       ir_ld,
  output logic       pc_inc,
  output logic       pc_ld,
  output logic       in1_sel,
  output logic       alu_en,
  output logic [2:0] alu_sel,
  output logic       acc_ld,
  output logic       instr_done,
  output logic       halted
);

  state_t state;
  state_t state_nxt;

  // State register; an asynchronous reset abandons any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and output decode from (state, opcode)
  always_comb begin
    state_nxt  = state;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    addr_sel   = 1'b0;
    ir_ld      = 1'b0;
    pc_inc     = 1'b0;
    pc_ld      = 1'b0;
    in1_sel    = 1'b0;
    alu_en     = 1'b0;
    alu_sel    = ALU_PASS;
    acc_ld     = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_rd    = 1'b1;
        state_nxt = S_IR;
      end
      S_IR: begin
        ir_ld     = 1'b1;
        pc_inc    = 1'b1;
        state_nxt = S_DEC;
      end
      S_DEC: begin
        case (opcode)
          OP_HLT: begin
            instr_done = 1'b1;
            state_nxt  = S_HALT;
          end
          OP_JMP: begin
            pc_ld      = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
          end
          OP_STO: begin
            addr_sel   = 1'b1;
            mem_wr     = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
          end
          OP_SKZ: begin
            alu_en    = 1'b1;
            alu_sel   = ALU_ZERO;
            state_nxt = S_SKZ;
          end
          default: begin
            // ADD/SUB/SHL/LDA read their operand from IR[4:0]
            addr_sel  = 1'b1;
            mem_rd    = 1'b1;
            state_nxt = S_OPND;
          end
        endcase
      end
      S_OPND: begin
        alu_en = 1'b1;
        case (opcode)
          OP_ADD:  alu_sel = ALU_ADD;
          OP_SUB:  alu_sel = ALU_SUB;
          OP_SHL:  alu_sel = ALU_SHL;
          default: begin
            // LDA passes memory data straight through on in1
            alu_sel = ALU_PASS;
            in1_sel = 1'b1;
          end
        endcase
        state_nxt = S_WB;
      end
      S_WB: begin
        acc_ld     = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_SKZ: begin
        // Skipping is just one extra PC increment when the accumulator is zero
        pc_inc     = alu_zero;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobe exclusivity
  a_mem_excl: assert property (@(posedge clk) disable iff (!rst_n) !(mem_rd && mem_wr));
  a_pc_excl:  assert property (@(posedge clk) disable iff (!rst_n) !(pc_inc && pc_ld));
  a_acc_excl: assert property (@(posedge clk) disable iff (!rst_n) !(acc_ld && alu_en));

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl. Expected strobes come from a per-cycle
// instruction timing table written from the instruction set description.
module tb_cpu_ctrl;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] opcode;
  logic       alu_zero;
  logic       mem_rd, mem_wr, addr_sel, ir_ld, pc_inc, pc_ld, in1_sel, alu_en;
  logic [2:0] alu_sel;
  logic       acc_ld, instr_done, halted;

  always #5 clk = ~clk;

  cpu_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .opcode     (opcode),
    .alu_zero   (alu_zero),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .addr_sel   (addr_sel),
    .ir_ld      (ir_ld),
    .pc_inc     (pc_inc),
    .pc_ld      (pc_ld),
    .in1_sel    (in1_sel),
    .alu_en     (alu_en),
    .alu_sel    (alu_sel),
    .acc_ld     (acc_ld),
    .instr_done (instr_done),
    .halted     (halted)
  );

  // Output vector bit masks
  localparam logic [13:0] M_RD   = 14'h2000;
  localparam logic [13:0] M_WR   = 14'h1000;
  localparam logic [13:0] M_ADDR = 14'h0800;
  localparam logic [13:0] M_IRLD = 14'h0400;
  localparam logic [13:0] M_PCI  = 14'h0200;
  localparam logic [13:0] M_PCL  = 14'h0100;
  localparam logic [13:0] M_IN1  = 14'h0080;
  localparam logic [13:0] M_ALU  = 14'h0040;
  localparam logic [13:0] M_ACC  = 14'h0004;
  localparam logic [13:0] M_DONE = 14'h0002;
  localparam logic [13:0] M_HALT = 14'h0001;

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];

  function automatic logic [13:0] sel(input logic [2:0] s);
    return {8'd0, s, 3'd0};
  endfunction

  function automatic logic [13:0] obs();
    return {mem_rd, mem_wr, addr_sel, ir_ld, pc_inc, pc_ld, in1_sel, alu_en,
            alu_sel, acc_ld, instr_done, halted};
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check_eq(input string tag, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Instruction length in cycles from FETCH through the instr_done cycle
  function automatic int lat(input logic [2:0] op);
    case (op)
      3'b000, 3'b110, 3'b111: return 3;
      3'b001:                 return 4;
      default:                return 5;
    endcase
  endfunction

  // Strobes expected in cycle i of an instruction (i=0 is FETCH)
  function automatic logic [13:0] model(input logic [2:0] op, input int i, input logic az);
    logic [2:0] code;
    case (op)
      3'b010:  code = 3'b010;
      3'b011:  code = 3'b011;
      3'b100:  code = 3'b100;
      default: code = 3'b000;
    endcase
    case (i)
      0: return M_RD;
      1: return M_IRLD | M_PCI;
      2: case (op)
           3'b000:  return M_DONE;
           3'b111:  return M_PCL | M_DONE;
           3'b110:  return M_ADDR | M_WR | M_DONE;
           3'b001:  return M_ALU | sel(3'b001);
           default: return M_ADDR | M_RD;
         endcase
      3: if (op == 3'b001) return (az ? M_PCI : 14'd0) | M_DONE;
         else return M_ALU | sel(code) | ((op == 3'b101) ? M_IN1 : 14'd0);
      default: return M_ACC | M_DONE;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic st, input logic az, input logic [2:0] op,
                      input logic [13:0] exp, input string tag);
    @(posedge clk);
    #1;
    start    = st;
    alu_zero = az;
    opcode   = op;
    #1;
    check_eq(tag, obs(), exp);
  endtask

  // One instruction starting in FETCH; a HLT also sits in HALT for hold cycles
  task automatic run_instr(input logic [2:0] op, input int hold);
    int         n;
    int         done_at;
    logic       az[5];
    logic       st[5];
    logic [2:0] opd[5];
    n       = lat(op);
    done_at = -1;
    for (int i = 0; i < n; i++) begin
      az[i]  = 1'($urandom_range(0, 1));
      st[i]  = ($urandom_range(0, 3) == 0);
      opd[i] = (i < 2) ? 3'($urandom_range(0, 7)) : op;
      exp_q.push_back(model(op, i, az[i]));
    end
    for (int i = 0; i < n; i++) begin
      step(st[i], az[i], opd[i], exp_q.pop_front(), $sformatf("op%0d_cyc%0d", op, i));
      if (instr_done && done_at < 0) done_at = i;
    end
    check_eq($sformatf("latency_op%0d", op), 14'(done_at + 1), 14'(n));
    if (op == 3'b000) begin
      for (int j = 0; j < hold; j++)
        step(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), M_HALT, "halt_hold");
      step(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), M_HALT, "halt_resume");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    opcode   = 3'b000;
    alu_zero = 1'b0;
    #12;
    check_eq("reset_outs", obs(), 14'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'b010, 14'd0, "idle");
    step(1'b1, 1'b0, 3'b010, 14'd0, "idle_start");

    // Directed pass over the test plan sequences
    run_instr(3'b010, 0);
    run_instr(3'b001, 0);
    run_instr(3'b001, 0);
    run_instr(3'b111, 0);
    run_instr(3'b110, 0);
    run_instr(3'b000, 10);

    // Randomized instruction stream
    repeat (80) run_instr(3'($urandom_range(0, 7)), $urandom_range(1, 6));

    // Reset during OPND of a SUB
    step(1'b0, 1'b0, 3'($urandom_range(0, 7)), M_RD, "abort_fetch");
    step(1'b0, 1'b0, 3'($urandom_range(0, 7)), M_IRLD | M_PCI, "abort_ir");
    step(1'b1, 1'b0, 3'b011, M_ADDR | M_RD, "abort_dec");
    step(1'b0, 1'b0, 3'b011, M_ALU | sel(3'b011), "abort_opnd");
    #1 rst_n = 1'b0;
    #1 check_eq("abort_async_clear", obs(), 14'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'($urandom_range(0, 1)), 3'b011, 14'd0, "post_reset_idle");
    step(1'b1, 1'b0, 3'b011, 14'd0, "restart");
    run_instr(3'b011, 0);
    run_instr(3'b101, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Instruction sequencer for the simple 8-bit processor. It walks each instruction through fetch, decode, operand-read, execute and write-back, and drives the enables and selects of the program counter, instruction register, accumulator, operand memory and `alu`. It contains no datapath registers of its own, only the FSM and its output decode. It sits between the instruction/data memory and the `alu` + accumulator datapath.

## Interface
Parameters:
- none; all encodings come from `cpu_pkg`.

Ports:
- `clk` in 1: single system clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin or resume execution; sampled only in IDLE or HALT.
- `opcode` in 3: IR[7:5]; valid from the DEC state onward.
- `alu_zero` in 1: zero flag from `alu`; registered one cycle after `alu_en` with sel=001.
- `mem_rd` out 1: synchronous memory read; data valid on the next cycle.
- `mem_wr` out 1: memory write of accumulator to `IR[4:0]`.
- `addr_sel` out 1: memory address source; 0 = PC, 1 = `IR[4:0]`.
- `ir_ld` out 1: load IR from memory read data.
- `pc_inc` out 1: PC <= PC+1 (5-bit, wraps 31->0).
- `pc_ld` out 1: PC <= `IR[4:0]`.
- `in1_sel` out 1: `alu` in1 source; 0 = accumulator, 1 = memory read data.
- `alu_en` out 1: `alu` enable.
- `alu_sel` out 3: `alu` operation; 000 when `alu_en`=0.
- `acc_ld` out 1: accumulator <= `alu` out.
- `instr_done` out 1: one-cycle pulse in the final cycle of every instruction.
- `halted` out 1: high in HALT.

## Operation
- Opcodes:
  - 000 HLT
  - 001 SKZ (skip next instruction if acc==0)
  - 010 ADD
  - 011 SUB
  - 100 SHL
  - 101 LDA
  - 110 STO
  - 111 JMP
- States: IDLE, FETCH, IR, DEC, OPND, SKZ, WB, HALT. Outputs are a pure decode of (state, opcode); anything not listed is 0.
- IDLE: outputs 0. `start` -> FETCH, else stay.
- FETCH: `addr_sel`=0, `mem_rd`=1 -> IR.
- IR: `ir_ld`=1, `pc_inc`=1 -> DEC.
- DEC, by opcode:
  - HLT: `instr_done`=1 -> HALT.
  - JMP: `pc_ld`=1, `instr_done`=1 -> FETCH.
  - STO: `addr_sel`=1, `mem_wr`=1, `instr_done`=1 -> FETCH.
  - SKZ: `alu_en`=1, `alu_sel`=001, `in1_sel`=0 -> SKZ.
  - ADD/SUB/SHL/LDA: `addr_sel`=1, `mem_rd`=1 -> OPND.
- OPND: `alu_en`=1.
  - ADD: sel 010.
  - SUB: sel 011.
  - SHL: sel 100.
  - LDA: sel 000 with `in1_sel`=1.
  - ADD/SUB/SHL use `in1_sel`=0, in2 = memory data. -> WB.
- WB: `acc_ld`=1, `instr_done`=1 -> FETCH.
- SKZ: `pc_inc`=`alu_zero`, `instr_done`=1 -> FETCH.
- HALT: `halted`=1. `start` -> FETCH (PC is not cleared, so execution resumes at the instruction after HLT).
- Arithmetic is 8-bit modulo and owned by `alu`; this block never inspects data.

## Timing
- Reset: state=IDLE asynchronously. All outputs 0 immediately, since they decode from the state register.
- Reset mid-instruction: the instruction is abandoned and no further strobes are issued. PC, IR and acc are reset by their own owners.
- Latency in cycles from FETCH entry to the cycle after `instr_done`:
  - ADD/SUB/SHL/LDA: 5
  - SKZ: 4
  - JMP/STO/HLT: 3
- `start` is ignored outside IDLE/HALT. A `start` held high through HALT resumes on the next cycle.
- Exclusivity, checked by assertion:
  - `mem_rd` and `mem_wr` are never both high.
  - `pc_inc` and `pc_ld` are never both high.
  - `acc_ld` is never high in the same cycle as `alu_en`.
- PC wrap at 31 is legal and silent.

## Structure
- `cpu_pkg` holds the opcode localparams, `alu` sel codes (PASS=000, ZERO=001, ADD=010, SUB=011, SHL=100) and the FSM state encoding, shared with `alu` and the top level.
- One always block for the state register (async `rst_n`) and one combinational next-state/output decode. No sub-module is needed.

## Test plan
- Reset then `start` pulse, `opcode`=010 -> FETCH, IR, DEC, OPND (`alu_en`=1, `alu_sel`=010), WB (`acc_ld`=1, `instr_done`=1) over 5 cycles, then FETCH.
- `opcode`=001 with `alu_zero`=1 -> `pc_inc` high in both the IR and SKZ states. Same with `alu_zero`=0 -> `pc_inc` only in IR.
- `opcode`=111 -> `pc_ld`=1 in DEC, `instr_done` on the 3rd cycle. `opcode`=110 -> `mem_wr`=1, `addr_sel`=1 in DEC.
- `opcode`=000 -> `halted`=1 and stays there with `start`=0 for 10 cycles. A `start` pulse then gives FETCH.
- Deassert `rst_n` during OPND of a SUB -> all outputs 0 in the same cycle, state IDLE; no `acc_ld` after reset is released.
- `start` pulsed during DEC -> ignored; the sequence is unchanged.
